// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the sequential calculator.
//   op_e    - operation select, same two-bit code as the push-button selector
//   state_e - control FSM states of seq_calculator
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/calc_muldiv_core.sv
// calc_muldiv_core: shared iterative datapath for shift-add multiply and
// restoring divide, one bit per step.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - capture operands and clear the accumulator
//   is_mul       - mode captured on load: 1 multiply, 0 divide
//   a, b         - operands (multiplicand/multiplier or dividend/divisor)
//   step         - perform one iteration
//   last         - the step being taken now is the final one
//   step_result  - product or zero-extended quotient after the current step
//   step_rem     - partial remainder after the current step (0 for multiply)
module calc_muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 is_mul,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic                 last,
  output logic [2*WIDTH-1:0]   step_result,
  output logic [WIDTH-1:0]     step_rem
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc: product accumulator in multiply mode; low half is the partial
  // remainder in divide mode. shreg: multiplier bits (shifted right) or
  // dividend bits shifted out MSB first with quotient bits shifted in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   opnd;
  logic               mul_mode;
  logic [CW-1:0]      cnt;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next_mul;

  assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, opnd} : '0);
  assign acc_next_mul = {mul_sum, acc[WIDTH-1:1]};

  // Divide: bring in the next dividend bit; the remainder is always below the
  // divisor, so the trial value fits in WIDTH+1 bits and, when it is >= the
  // divisor, the difference fits in WIDTH bits.
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign trial    = {acc[WIDTH-1:0], shreg[WIDTH-1]};
  assign q_bit    = (trial >= {1'b0, opnd});
  assign rem_next = q_bit ? (trial[WIDTH-1:0] - opnd) : trial[WIDTH-1:0];
  assign quo_next = {shreg[WIDTH-2:0], q_bit};

  assign step_result = mul_mode ? acc_next_mul : {{WIDTH{1'b0}}, quo_next};
  assign step_rem    = mul_mode ? '0 : rem_next;
  assign last        = (cnt == CW'(1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      mul_mode <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      acc      <= '0;
      shreg    <= is_mul ? b : a;
      opnd     <= is_mul ? a : b;
      mul_mode <= is_mul;
      cnt      <= CW'(WIDTH);
    end else if (step) begin
      if (mul_mode) begin
        acc   <= acc_next_mul;
        shreg <= shreg >> 1;
      end else begin
        acc   <= {{WIDTH{1'b0}}, rem_next};
        shreg <= quo_next;
      end
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle unsigned calculator with start/busy/done
// handshake. Add and sub complete in one step; mul and div iterate WIDTH
// times in calc_muldiv_core.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request, sampled only in IDLE
//   op          - 00 add, 01 sub, 10 div, 11 mul
//   a, b        - operands (a: dividend/minuend, b: divisor/subtrahend)
//   result      - sum, difference, quotient or product, zero-extended
//   remainder   - division remainder, 0 for other ops
//   flag        - carry (add) or borrow (sub), 0 otherwise
//   div_by_zero - last completed op was a divide with b == 0
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse when the outputs have been updated
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 flag,
  output logic                 div_by_zero,
  output logic                 busy,
  output logic                 done
);

  state_e state;
  op_e    op_sel;
  logic   accept;
  logic   b_zero;
  logic   core_load;
  logic   core_step;
  logic   core_last;
  logic [2*WIDTH-1:0] core_result;
  logic [WIDTH-1:0]   core_rem;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;

  assign op_sel   = op_e'(op);
  assign accept   = (state == ST_IDLE) && start;
  assign b_zero   = (b == '0);
  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = a - b;

  // The core captures operands on the accepting edge itself, so later input
  // changes cannot disturb an iteration in progress.
  assign core_load = accept && ((op_sel == OP_MUL) || ((op_sel == OP_DIV) && !b_zero));
  assign core_step = (state == ST_MUL) || (state == ST_DIV);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  calc_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (core_load),
    .is_mul      (op_sel == OP_MUL),
    .a           (a),
    .b           (b),
    .step        (core_step),
    .last        (core_last),
    .step_result (core_result),
    .step_rem    (core_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      result      <= '0;
      remainder   <= '0;
      flag        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op_sel)
              OP_ADD: begin
                state       <= ST_DONE;
                result      <= {{(WIDTH-1){1'b0}}, add_sum};
                remainder   <= '0;
                flag        <= add_sum[WIDTH];
                div_by_zero <= 1'b0;
              end
              OP_SUB: begin
                state       <= ST_DONE;
                result      <= {{WIDTH{1'b0}}, sub_diff};
                remainder   <= '0;
                flag        <= (a < b);
                div_by_zero <= 1'b0;
              end
              OP_DIV: begin
                if (b_zero) begin
                  state       <= ST_DONE;
                  result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                  remainder   <= a;
                  flag        <= 1'b0;
                  div_by_zero <= 1'b1;
                end else begin
                  state <= ST_DIV;
                end
              end
              OP_MUL: state <= ST_MUL;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) begin
            state       <= ST_DONE;
            result      <= core_result;
            remainder   <= core_rem;
            flag        <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: scoreboard bench for seq_calculator at WIDTH=8.
// Expected results are pushed when a request is issued and popped when the
// DUT pulses done.
module tb_seq_calculator;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           flag;
  logic           div_by_zero;
  logic           busy;
  logic           done;

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           flag;
    logic           dbz;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  seq_calculator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .result      (result),
    .remainder   (remainder),
    .flag        (flag),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request so it is accepted at the next rising edge (edge k) and
  // push the reference-model expectation. Returns 1 ns after edge k,
  // with the operand inputs scrambled to show they are not re-sampled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0]   s;
    logic [W-1:0] d;
    e.rem  = '0;
    e.flag = 1'b0;
    e.dbz  = 1'b0;
    e.lat  = 1;
    case (o)
      2'b00: begin
        s = {1'b0, x} + {1'b0, y};
        e.res  = {7'b0, s};
        e.flag = s[W];
      end
      2'b01: begin
        d = x - y;
        e.res  = {8'b0, d};
        e.flag = (x < y);
      end
      2'b10: begin
        if (y == 0) begin
          e.res = 16'h00FF;
          e.rem = x;
          e.dbz = 1'b1;
        end else begin
          e.res = 16'(x / y);
          e.rem = x % y;
          e.lat = W + 1;
        end
      end
      default: begin
        e.res = 16'(x) * 16'(y);
        e.lat = W + 1;
      end
    endcase
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  // Wait for done (n = cycles since edge k, 1 = the cycle after edge k),
  // pop the scoreboard and compare, then confirm the pulse lasted one cycle
  // and the outputs hold in IDLE.
  task automatic collect(input int n0, input string tag);
    exp_t e;
    int   n;
    n = n0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: done with empty scoreboard", tag);
      return;
    end
    e = exp_q.pop_front();
    if (n !== e.lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", tag, n, e.lat);
    end
    vectors++;
    if (result !== e.res) begin
      miscompares++;
      $display("FAIL %s result: got %h expected %h", tag, result, e.res);
    end
    vectors++;
    if (remainder !== e.rem) begin
      miscompares++;
      $display("FAIL %s remainder: got %h expected %h", tag, remainder, e.rem);
    end
    vectors++;
    if (flag !== e.flag) begin
      miscompares++;
      $display("FAIL %s flag: got %b expected %b", tag, flag, e.flag);
    end
    vectors++;
    if (div_by_zero !== e.dbz) begin
      miscompares++;
      $display("FAIL %s div_by_zero: got %b expected %b", tag, div_by_zero, e.dbz);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy at done: got %b expected 1", tag, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s after done {done,busy}: got %b expected 00", tag, {done, busy});
    end
    vectors++;
    if (result !== e.res) begin
      miscompares++;
      $display("FAIL %s hold result: got %h expected %h", tag, result, e.res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #1;
    vectors++;
    if ({result, remainder, flag, div_by_zero, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h expected 0",
               {result, remainder, flag, div_by_zero, busy, done});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(2'b00, 8'd200, 8'd100);
    collect(1, "add_200_100");
  endtask

  task automatic test_sub();
    issue(2'b01, 8'd5, 8'd9);
    collect(1, "sub_5_9");
    issue(2'b01, 8'd9, 8'd5);
    collect(1, "sub_9_5");
  endtask

  // A second start with op=add arrives at edge k+3 while mul is iterating.
  task automatic test_mul_ignored_start();
    issue(2'b11, 8'd255, 8'd255);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 8'd1;
    b     = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect(4, "mul_255_255");
  endtask

  task automatic test_div();
    issue(2'b10, 8'd200, 8'd7);
    collect(1, "div_200_7");
  endtask

  task automatic test_div_by_zero();
    issue(2'b10, 8'd13, 8'd0);
    collect(1, "div_13_0");
    issue(2'b00, 8'd1, 8'd1);
    collect(1, "add_after_dbz");
  endtask

  task automatic test_reset_mid_op();
    logic saw_done;
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 8'd17;
    b     = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({result, remainder, flag, div_by_zero, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_op outputs: got %h expected 0",
               {result, remainder, flag, div_by_zero, busy, done});
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      saw_done |= done;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_op done pulse: got %b expected 0", saw_done);
    end
    issue(2'b10, 8'd100, 8'd10);
    collect(1, "div_100_10");
  endtask

  // Requests issued at the earliest eligible edge, one after another.
  task automatic test_back_to_back();
    logic [1:0] o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 16; i++) begin
      o = 2'(i % 4);
      x = 8'($urandom);
      y = (i == 6) ? 8'd0 : 8'($urandom);
      issue(o, x, y);
      collect(1, "back_to_back");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul_ignored_start();
    test_div();
    test_div_by_zero();
    test_reset_mid_op();
    test_back_to_back();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, multi-cycle unsigned calculator for the board-level calculator top. It accepts two WIDTH-bit operands and an op code (add, subtract, divide, multiply, using the same two-bit encoding as the push-button selector), then returns a registered result with a start/busy/done handshake. Multiply uses iterative shift-add and divide uses restoring division, one bit per cycle. This replaces the fixed 4-bit free-running operation blocks and their output mux.

## Interface
- WIDTH, 8, operand width in bits; legal values are 2 to 32.
- clk  in  1  the single clock; every register is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation select: 00 add, 01 sub, 10 div, 11 mul.
- a  in  WIDTH  first operand (dividend, minuend).
- b  in  WIDTH  second operand (divisor, subtrahend).
- result  out  2*WIDTH  sum, difference, quotient or product, zero-extended.
- remainder  out  WIDTH  division remainder; 0 for other ops.
- flag  out  1  carry for add, borrow for sub, 0 for mul and div.
- div_by_zero  out  1  set when a div had b == 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the outputs are updated.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with start=1 latches a, b and op. start is ignored in every other state.
- add: result = a + b in WIDTH+1 bits; flag = result[WIDTH]. Next state DONE.
- sub: result[WIDTH-1:0] = (a - b) mod 2^WIDTH; upper bits 0; flag = (a < b). Next state DONE.
- div with b == 0: result = all ones in [WIDTH-1:0] and zero above; remainder = a; div_by_zero = 1. Next state DONE.
- div with b != 0: next state DIV. Restoring division runs MSB first: the partial remainder shifts left by one and takes in the next dividend bit. If partial remainder >= b, subtract b and set the quotient bit. WIDTH iterations, then DONE.
- mul: next state MUL. Shift-add over the bits of b, LSB first, with a 2*WIDTH accumulator. WIDTH iterations, then DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- result, remainder, flag and div_by_zero update only on entry to DONE. They hold their values until the next accepted start completes.
- div_by_zero and flag clear on every completion that does not set them.
- An iteration counter of clog2(WIDTH+1) bits counts down from WIDTH to 0.

## Timing
- Reset values: state IDLE; result, remainder, flag, div_by_zero, busy and done all 0. This applies immediately, independent of clk.
- Reset asserted mid-operation aborts the operation. No done pulse is produced, and outputs return to their reset values.
- Start is accepted at rising edge k.
  - add, sub, and div by zero: done is high during cycle k+1.
  - mul and div: iterations run at edges k+1 through k+WIDTH; done is high during cycle k+WIDTH+1.
- busy rises in the cycle after edge k and falls in the cycle after done.
- Earliest next accepted start: the edge that ends the done cycle is not eligible; the following edge is. Throughput is therefore 2 cycles for add/sub and WIDTH+2 cycles for mul/div.
- Operand or op changes after edge k have no effect on the operation in progress.

## Structure
- Package calc_pkg holds:
  - the op enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11);
  - the state enum.
- Sub-module calc_muldiv_core holds the shared iterative datapath: accumulator/partial-remainder register, shift register, counter, and the per-step add/compare-subtract.
  - The top FSM drives its load and step controls and reads its last-step flag.
  - Add and sub stay in the top level.

## Test plan
All cases use WIDTH=8.
- add: a=200, b=100 -> done in cycle k+1; result=0x012C, flag=1, busy high for exactly one cycle.
- sub: a=5, b=9 -> result=0x00FC, flag=1. Then sub a=9, b=5 -> result=0x0004, flag=0.
- mul: a=255, b=255 -> done in cycle k+9; result=0xFE01. A second start pulse at k+3 with op=add is ignored, and the result is still 0xFE01.
- div: a=200, b=7 -> done in cycle k+9; result=28, remainder=4, div_by_zero=0.
- div by zero: a=13, b=0 -> done in cycle k+1; result=0x00FF, remainder=13, div_by_zero=1. A following add 1+1 gives result=2 and div_by_zero=0.
- reset mid-op:
  - Start mul 17*3, then drop rst_n at k+4. All outputs go to 0 with no done pulse.
  - Release rst_n and start div 100/10 -> result=10, remainder=0.
